// File: rtl/draw_scheduler_if.sv
// Bundle of frame control, requester, sprite ROM and pixel-write signals for draw_scheduler.
// "master" is the scheduler side; "slave" is the requesters, ROM and frame-buffer side.
interface draw_scheduler_if #(
    parameter int NREQ = 4
);
    logic                 frame_start;
    logic [NREQ-1:0]      req;
    logic [NREQ*9-1:0]    req_x;
    logic [NREQ*8-1:0]    req_y;
    logic [NREQ-1:0]      grant;
    logic [7:0]           rom_addr;
    logic [11:0]          rom_data;
    logic [8:0]           x;
    logic [7:0]           y;
    logic [11:0]          colour;
    logic                 plot;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  frame_start, req, req_x, req_y, rom_data,
        output grant, rom_addr, x, y, colour, plot, busy, frame_done
    );

    modport slave (
        output frame_start, req, req_x, req_y, rom_data,
        input  grant, rom_addr, x, y, colour, plot, busy, frame_done
    );
endinterface

// File: rtl/draw_scheduler.sv
// Frame draw scheduler: fills the background, then draws each requesting sprite once per frame,
// lowest index first, streaming pixels from a shared synchronous sprite ROM with clipping.
module draw_scheduler #(
    parameter int          NREQ        = 4,
    parameter int          SCR_W       = 320,
    parameter int          SCR_H       = 240,
    parameter int          SPR_DIM     = 16,
    parameter logic [11:0] BG_COLOUR   = 12'h884,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input logic               CLOCK_50,
    input logic               reset,
    draw_scheduler_if.master  bus
);
    localparam int         SB        = $clog2(SPR_DIM);
    localparam logic [7:0] LAST_ADDR = 8'(SPR_DIM * SPR_DIM - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BG    = 3'd1;
    localparam logic [2:0] S_ARB   = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] served_q, served_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [8:0]      lx_q, lx_d;
    logic [7:0]      ly_q, ly_d;
    logic [8:0]      fx_q, fx_d;
    logic [7:0]      fy_q, fy_d;
    logic [7:0]      rom_addr_q, rom_addr_d;
    logic [7:0]      pix_addr_q;
    logic            pix_vld_q;
    logic [8:0]      hx_q;
    logic [7:0]      hy_q;
    logic [11:0]     hc_q;

    logic            cand_found;
    logic [NREQ-1:0] cand_oh;
    logic [8:0]      cand_x;
    logic [7:0]      cand_y;

    logic [9:0]      spr_x;
    logic [8:0]      spr_y;
    logic            spr_plot;

    logic [8:0]      x_o;
    logic [7:0]      y_o;
    logic [11:0]     c_o;
    logic            plot_o;

    // Scan downwards so the lowest eligible index is the one left standing.
    always_comb begin
        cand_found = 1'b0;
        cand_oh    = '0;
        cand_x     = '0;
        cand_y     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i] && !served_q[i]) begin
                cand_found = 1'b1;
                cand_oh    = NREQ'(1) << i;
                cand_x     = bus.req_x[9*i +: 9];
                cand_y     = bus.req_y[8*i +: 8];
            end
        end
    end

    // Sums are one bit wider than the screen coordinate so off-screen pixels cannot wrap back on.
    assign spr_x    = {1'b0, lx_q} + 10'(pix_addr_q[SB-1:0]);
    assign spr_y    = {1'b0, ly_q} + 9'(pix_addr_q[2*SB-1:SB]);
    assign spr_plot = pix_vld_q && (spr_x < 10'(SCR_W)) && (spr_y < 9'(SCR_H))
                      && (bus.rom_data != TRANSPARENT);

    always_comb begin
        plot_o = 1'b0;
        x_o    = hx_q;
        y_o    = hy_q;
        c_o    = hc_q;
        if (state_q == S_BG) begin
            plot_o = 1'b1;
            x_o    = fx_q;
            y_o    = fy_q;
            c_o    = BG_COLOUR;
        end else if (spr_plot) begin
            plot_o = 1'b1;
            x_o    = spr_x[8:0];
            y_o    = spr_y[7:0];
            c_o    = bus.rom_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        grant_d    = grant_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        rom_addr_d = rom_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d  = S_BG;
                    served_d = '0;
                    fx_d     = '0;
                    fy_d     = '0;
                end
            end
            S_BG: begin
                if (fx_q == 9'(SCR_W - 1)) begin
                    fx_d = '0;
                    if (fy_q == 8'(SCR_H - 1)) begin
                        fy_d    = '0;
                        state_d = S_ARB;
                    end else begin
                        fy_d = fy_q + 8'd1;
                    end
                end else begin
                    fx_d = fx_q + 9'd1;
                end
            end
            S_ARB: begin
                if (cand_found) begin
                    state_d    = S_DRAW;
                    grant_d    = cand_oh;
                    served_d   = served_q | cand_oh;
                    lx_d       = cand_x;
                    ly_d       = cand_y;
                    rom_addr_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAW: begin
                rom_addr_d = rom_addr_q + 8'd1;
                if (rom_addr_q == LAST_ADDR) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                grant_d = '0;
                state_d = S_ARB;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            served_q   <= '0;
            grant_q    <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            rom_addr_q <= '0;
            pix_addr_q <= '0;
            pix_vld_q  <= 1'b0;
            hx_q       <= '0;
            hy_q       <= '0;
            hc_q       <= '0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            grant_q    <= grant_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            rom_addr_q <= rom_addr_d;
            // ROM answers one cycle later, so the address and its valid ride one stage behind.
            pix_addr_q <= rom_addr_q;
            pix_vld_q  <= (state_q == S_DRAW);
            hx_q       <= x_o;
            hy_q       <= y_o;
            hc_q       <= c_o;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.x          = x_o;
    assign bus.y          = y_o;
    assign bus.colour     = c_o;
    assign bus.plot       = plot_o;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = (state_q == S_DONE);
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
Parameters (name, default, meaning):
REQ-001 NREQ, 4, number of sprite requesters.
REQ-002 SCR_W, 320, screen width in pixels; SCR_H, 240, screen height in pixels.
REQ-003 SPR_DIM, 16, sprite edge length; the sprite ROM holds SPR_DIM*SPR_DIM words, row-major.
REQ-004 BG_COLOUR, 12'h884, background fill colour.
REQ-005 TRANSPARENT, 12'h000, ROM colour value that is never plotted.

Ports (name, direction, width, meaning):
REQ-006 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 frame_start  in  1  request for a new frame: background fill, then sprites.
REQ-009 req  in  NREQ  per-requester sprite draw request, level.
REQ-010 req_x  in  NREQ*9  sprite top-left x; requester i uses bits [9i+8:9i].
REQ-011 req_y  in  NREQ*8  sprite top-left y; requester i uses bits [8i+7:8i].
REQ-012 grant  out  NREQ  one-hot; marks the requester currently being drawn.
REQ-013 rom_addr  out  8  shared sprite ROM address; the ROM is synchronous with 1-cycle read latency.
REQ-014 rom_data  in  12  ROM output for the address presented on the previous cycle.
REQ-015 x, y, colour, plot  out  9, 8, 12, 1  pixel-write port to vga_adapter.
REQ-016 busy  out  1  high whenever the block is not in IDLE; frame_done  out  1  single-cycle end-of-frame pulse.

Function
REQ-017 States: IDLE, BG_FILL, ARB, SPR_DRAW, SPR_FLUSH, DONE.
REQ-018 IDLE: if frame_start=1, go to BG_FILL, clear the served mask, and zero the fill counters; frame_start is ignored in all other states.
REQ-019 BG_FILL: write one pixel per cycle (plot=1, colour=BG_COLOUR), x inner 0..SCR_W-1, y outer 0..SCR_H-1; first pixel (0,0) appears on the cycle after IDLE exits.
REQ-020 BG_FILL lasts exactly SCR_W*SCR_H cycles, ending with pixel (319,239), then goes to ARB.
REQ-021 ARB (1 cycle, plot=0): select the lowest index i with req[i]=1 and served[i]=0; latch req_x[i] and req_y[i]; set grant to one-hot i and served[i] to 1; go to SPR_DRAW. With no candidate, go to DONE.
REQ-022 Lower indices are drawn first, so higher indices overlay them; each requester is drawn at most once per frame.
REQ-023 A requester that raises req after an ARB has passed it is still served at a later ARB of the same frame if it remains unserved.
REQ-024 SPR_DRAW: rom_addr steps 0..255, one per cycle, starting on the first SPR_DRAW cycle; after address 255, go to SPR_FLUSH.
REQ-025 Pixel pipeline: the output cycle for address a carries x=lx+(a mod 16), y=ly+(a div 16), colour=rom_data, so plot lags rom_addr by exactly 1 cycle.
REQ-026 plot is 1 only when the output pixel has x<SCR_W, y<SCR_H and rom_data!=TRANSPARENT; otherwise plot=0 and rom_addr still advances.
REQ-027 Coordinate sums are computed at 10/9 bits before the clip test, so an off-screen pixel never wraps onto the screen.
REQ-028 SPR_FLUSH (1 cycle): outputs the pixel for address 255, then goes to ARB; grant stays high from ARB exit through SPR_FLUSH.
REQ-029 Each sprite costs 258 cycles: ARB + 256 + flush.
REQ-030 Deasserting req[i] while requester i is granted does not abort its draw; req_x/req_y changes after the latch are ignored.
REQ-031 DONE (1 cycle): frame_done=1, plot=0, grant=0; go to IDLE.
REQ-032 When plot=0, x, y and colour hold their last values.

Reset
REQ-033 When reset=1 on an edge: state=IDLE, plot=0, grant=0, frame_done=0, busy=0, rom_addr=0, x=0, y=0, colour=0, served mask=0.
REQ-034 reset takes priority over every other input; when asserted mid-frame, no further plot occurs from the next cycle on.

Verification
REQ-035 Assert reset for 2 cycles with frame_start=1 -> all outputs 0; busy=0 on the cycle after release, with frame_start held low.
REQ-036 frame_start pulse with req=0 -> exactly 76800 plots of 12'h884 in raster order, last at (319,239), frame_done one cycle later after a single ARB, then busy=0.
REQ-037 req=4'b0101 at (10,20) and (100,50), ROM returning addr-dependent non-zero data -> grant=0001, then 256 plots covering x 10..25 and y 20..35; then grant=0100 covering x 100..115 and y 50..65; colour equals ROM[a] with 1-cycle alignment.
REQ-038 Single sprite at (312,232) -> rom_addr still covers 0..255 but only 64 plots occur, for x 312..319 and y 232..239.
REQ-039 ROM returns TRANSPARENT for even addresses -> 128 plots per sprite; frame_start pulsed mid-frame -> no restart, frame length unchanged.
REQ-040 reset asserted during the second sprite's SPR_DRAW -> plot=0 and grant=0 next cycle, state IDLE; a new frame_start then yields a full, correct frame.
